lzw_code_packer: RTL

//   Downstream of the LZW compressor. Takes its 12-bit output codes one at a time

---
 rtl/lzw_pkg.sv | 23 ++
 rtl/lzw_code_packer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lzw_pkg.sv
// -----------------------------------------------------------------------------
// lzw_pkg
//   Types and widths shared between the LZW compressor and the code packer.
//   LZW_CODE_W / LZW_BYTE_W : code and output byte widths
//   LZW_CNT_W               : width of the packer's per-stream byte counter
//   packer_state_t          : packer FSM states
// -----------------------------------------------------------------------------
package lzw_pkg;

    localparam int LZW_CODE_W = 12;
    localparam int LZW_BYTE_W = 8;
    localparam int LZW_CNT_W  = 16;

    typedef logic [LZW_CODE_W-1:0] lzw_code_t;
    typedef logic [LZW_BYTE_W-1:0] lzw_byte_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } packer_state_t;

endpackage

// File: rtl/lzw_code_packer.sv
// -----------------------------------------------------------------------------
// lzw_code_packer
//   Packs CODE_W-bit LZW codes MSB-first into a dense OUT_W-bit byte stream.
//   A code may straddle two bytes. At end of stream the final partial byte is
//   zero-padded and flagged as last; a one-cycle done pulse follows its accept.
//
// Ports
//   clk_i         in   clock, rising edge
//   reset_i       in   asynchronous active-high reset
//   code_valid_i  in   code_i valid
//   code_i        in   LZW code (CODE_W)
//   code_last_i   in   code_i is the final code of the stream
//   code_ready_o  out  packer accepts a code this cycle
//   byte_valid_o  out  byte_o valid
//   byte_o        out  packed output byte (OUT_W)
//   byte_last_o   out  byte_o is the final byte of the stream
//   byte_ready_i  in   consumer accepts the byte
//   done_o        out  pulse the cycle after the last byte is accepted
//   byte_count_o  out  bytes emitted in the current / most recent stream
//
// All outputs decode from registers only.
// -----------------------------------------------------------------------------
module lzw_code_packer
    import lzw_pkg::*;
#(
    parameter int CODE_W = LZW_CODE_W,
    parameter int OUT_W  = LZW_BYTE_W,
    parameter int CNT_W  = LZW_CNT_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              code_valid_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic              code_last_i,
    output logic              code_ready_o,
    output logic              byte_valid_o,
    output logic [OUT_W-1:0]  byte_o,
    output logic              byte_last_o,
    input  logic              byte_ready_i,
    output logic              done_o,
    output logic [CNT_W-1:0]  byte_count_o
);

    // Worst case: OUT_W-1 leftover bits plus one fresh code.
    localparam int ACC_W  = CODE_W + OUT_W - 1;
    localparam int FILL_W = $clog2(ACC_W + 1);

    localparam logic [FILL_W-1:0] FILL_OUT  = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] FILL_CODE = FILL_W'(CODE_W);
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};

    packer_state_t     r_state, w_state_nxt;
    logic [ACC_W-1:0]  r_acc, w_acc_nxt;
    logic [FILL_W-1:0] r_fill, w_fill_nxt;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic              r_first, w_first_nxt;   // next accepted code starts a stream

    logic              w_code_ready;
    logic              w_byte_valid;
    logic              w_byte_last;
    logic              w_code_acc;
    logic              w_byte_acc;
    logic [ACC_W-1:0]  w_code_aligned;

    // Handshake outputs decoded from state and fill level.
    always_comb begin
        w_code_ready = 1'b0;
        w_byte_valid = 1'b0;
        w_byte_last  = 1'b0;
        case (r_state)
            RUN: begin
                w_code_ready = (r_fill < FILL_OUT);
                w_byte_valid = (r_fill >= FILL_OUT);
            end
            DRAIN: begin
                w_byte_valid = (r_fill != FILL_ZERO);
                // Bits below the fill level are always zero, so the final
                // partial byte comes out already padded.
                w_byte_last  = (r_fill != FILL_ZERO) && (r_fill <= FILL_OUT);
            end
            DONE: begin
                w_code_ready = 1'b0;
            end
            default: begin
                w_code_ready = 1'b0;
            end
        endcase
    end

    assign w_code_acc     = code_valid_i && w_code_ready;
    assign w_byte_acc     = w_byte_valid && byte_ready_i;
    // Place the new code immediately below the bits already held.
    assign w_code_aligned = {code_i, {(ACC_W-CODE_W){1'b0}}} >> r_fill;

    // Next-state, accumulator, fill and counter update.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_fill_nxt  = r_fill;
        w_count_nxt = r_count;
        w_first_nxt = r_first;
        case (r_state)
            RUN: begin
                if (w_code_acc) begin
                    w_acc_nxt   = r_acc | w_code_aligned;
                    w_fill_nxt  = r_fill + FILL_CODE;
                    w_first_nxt = 1'b0;
                    if (r_first) begin
                        w_count_nxt = {CNT_W{1'b0}};
                    end else begin
                        w_count_nxt = r_count;
                    end
                    if (code_last_i) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else if (w_byte_acc) begin
                    w_acc_nxt   = r_acc << OUT_W;
                    w_fill_nxt  = r_fill - FILL_OUT;
                    w_count_nxt = r_count + CNT_W'(1);
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (w_byte_acc) begin
                    w_acc_nxt   = r_acc << OUT_W;
                    w_count_nxt = r_count + CNT_W'(1);
                    if (w_byte_last) begin
                        w_fill_nxt  = FILL_ZERO;
                        w_state_nxt = DONE;
                    end else begin
                        w_fill_nxt  = r_fill - FILL_OUT;
                    end
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            DONE: begin
                w_acc_nxt   = {ACC_W{1'b0}};
                w_fill_nxt  = FILL_ZERO;
                w_first_nxt = 1'b1;
                w_state_nxt = RUN;
            end
            default: begin
                w_acc_nxt   = {ACC_W{1'b0}};
                w_fill_nxt  = FILL_ZERO;
                w_first_nxt = 1'b1;
                w_state_nxt = RUN;
            end
        endcase
    end

    // State register; reset discards any stream in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= RUN;
            r_acc   <= {ACC_W{1'b0}};
            r_fill  <= FILL_ZERO;
            r_count <= {CNT_W{1'b0}};
            r_first <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_fill  <= w_fill_nxt;
            r_count <= w_count_nxt;
            r_first <= w_first_nxt;
        end
    end

    assign code_ready_o = w_code_ready;
    assign byte_valid_o = w_byte_valid;
    assign byte_o       = r_acc[ACC_W-1 -: OUT_W];
    assign byte_last_o  = w_byte_last;
    assign done_o       = (r_state == DONE);
    assign byte_count_o = r_count;

endmodule
